// File: rtl/xbar_pkg.sv
// Shared constants and helpers for the configurable crossbar tile.
// Holds the default tile geometry and the log2 helper used to size selects and counters.
package xbar_pkg;

    localparam int DEF_N_IN  = 19;
    localparam int DEF_N_OUT = 24;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/xbar_mux.sv
// One crossbar output: N_IN:1 selector that yields 0 for out-of-range selects.
module xbar_mux
    import xbar_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int SEL_W = clog2(DEF_N_IN)
) (
    input  logic [N_IN-1:0]  din,
    input  logic [SEL_W-1:0] sel,
    output logic             dout
);

    // A one-hot compare per input keeps unused select codes mapped to 0.
    always_comb begin
        dout = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                dout = din[i];
            end
        end
    end

endmodule

// File: rtl/cfg_xbar.sv
// Serially configured bit crossbar: a shift-in shadow config is committed
// atomically into the active config that steers N_OUT selectors.
module cfg_xbar
    import xbar_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int REG_OUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  io_xbar_in,
    output logic [N_OUT-1:0] io_xbar_out,
    input  logic             io_cfg_en,
    input  logic             io_cfg_din,
    output logic             io_cfg_dout,
    input  logic             io_cfg_commit,
    output logic             io_cfg_ready,
    output logic             io_cfg_err
);

    localparam int SEL_W = clog2(N_IN);
    localparam int CFG_W = N_OUT * SEL_W;
    localparam int CNT_W = clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

    logic [CFG_W-1:0] shadow_reg, shadow_next;
    logic [CFG_W-1:0] active_reg, active_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             err_reg, err_next;
    logic             cfg_full;
    logic             commit_ok;
    logic [N_OUT-1:0] mux_out;

    assign cfg_full  = (count_reg == CNT_FULL);
    assign commit_ok = io_cfg_commit && !io_cfg_en && cfg_full;

    // A commit is only honoured when the shadow holds a complete, quiescent image.
    always_comb begin
        shadow_next = shadow_reg;
        active_next = active_reg;
        count_next  = count_reg;
        err_next    = err_reg;
        if (io_cfg_en) begin
            shadow_next = CFG_W'({shadow_reg, io_cfg_din});
            if (!cfg_full) begin
                count_next = count_reg + 1'b1;
            end
        end
        if (commit_ok) begin
            active_next = shadow_reg;
            count_next  = '0;
        end else if (io_cfg_commit) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_reg <= '0;
            active_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            shadow_reg <= shadow_next;
            active_reg <= active_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
        end
    end

    assign io_cfg_dout  = shadow_reg[CFG_W-1];
    assign io_cfg_ready = cfg_full;
    assign io_cfg_err   = err_reg;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_mux
        xbar_mux #(
            .N_IN  (N_IN),
            .SEL_W (SEL_W)
        ) u_mux (
            .din  (io_xbar_in),
            .sel  (active_reg[gi*SEL_W +: SEL_W]),
            .dout (mux_out[gi])
        );
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [N_OUT-1:0] out_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                out_reg <= '0;
            end else begin
                out_reg <= mux_out;
            end
        end
        assign io_xbar_out = out_reg;
    end else begin : g_comb_out
        assign io_xbar_out = mux_out;
    end

endmodule

// File: tb/tb_cfg_xbar.sv
// Bench for cfg_xbar: a combinational and a registered instance share stimulus
// and are compared against a queue-based model of the shadow/active configuration.
module tb_cfg_xbar;

    localparam int N_IN  = 19;
    localparam int N_OUT = 24;
    localparam int SEL_W = 5;
    localparam int CFG_W = 120;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [N_IN-1:0]  xin;
    logic             cfg_en, cfg_din, cfg_commit;
    logic [N_OUT-1:0] out0, out1;
    logic             dout0, dout1, ready0, ready1, err0, err1;

    cfg_xbar #(.N_IN(N_IN), .N_OUT(N_OUT), .REG_OUT(0)) dut0 (
        .clk(clk), .reset(reset), .io_xbar_in(xin), .io_xbar_out(out0),
        .io_cfg_en(cfg_en), .io_cfg_din(cfg_din), .io_cfg_dout(dout0),
        .io_cfg_commit(cfg_commit), .io_cfg_ready(ready0), .io_cfg_err(err0)
    );

    cfg_xbar #(.N_IN(N_IN), .N_OUT(N_OUT), .REG_OUT(1)) dut1 (
        .clk(clk), .reset(reset), .io_xbar_in(xin), .io_xbar_out(out1),
        .io_cfg_en(cfg_en), .io_cfg_din(cfg_din), .io_cfg_dout(dout1),
        .io_cfg_commit(cfg_commit), .io_cfg_ready(ready1), .io_cfg_err(err1)
    );

    int checks = 0;
    int errors = 0;

    // Model: hist[i] is the bit shifted in i shifts ago (shadow bit i).
    bit               hist[$];
    int               m_active[N_OUT];
    int               m_count;
    bit               m_err;
    logic [N_OUT-1:0] m_out1;
    int               cfg_sel[N_OUT];

    function automatic int shadow_sel(input int k);
        int s = 0;
        for (int j = 0; j < SEL_W; j++) begin
            int idx = k * SEL_W + j;
            if (idx < hist.size() && hist[idx]) s += (1 << j);
        end
        return s;
    endfunction

    function automatic logic [N_OUT-1:0] route(input logic [N_IN-1:0] x);
        logic [N_OUT-1:0] r = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (m_active[k] < N_IN) r[k] = x[m_active[k]];
        end
        return r;
    endfunction

    function automatic bit m_dout();
        return (hist.size() >= CFG_W) ? hist[CFG_W-1] : 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            hist.delete();
            for (int k = 0; k < N_OUT; k++) m_active[k] = 0;
            m_count = 0;
            m_err   = 1'b0;
            m_out1  = '0;
        end else begin
            m_out1 = route(xin);
            if (cfg_commit && !cfg_en && m_count == CFG_W) begin
                for (int k = 0; k < N_OUT; k++) m_active[k] = shadow_sel(k);
                m_count = 0;
            end else if (cfg_commit) begin
                m_err = 1'b1;
            end
            if (cfg_en) begin
                hist.push_front(cfg_din);
                if (hist.size() > CFG_W) void'(hist.pop_back());
                if (m_count < CFG_W) m_count++;
            end
        end
        #1;
    endtask

    task automatic shift_bit(input bit b);
        cfg_en  = 1'b1;
        cfg_din = b;
        tick();
        cfg_en  = 1'b0;
        cfg_din = 1'b0;
    endtask

    task automatic load_cfg();
        for (int k = N_OUT - 1; k >= 0; k--) begin
            for (int j = SEL_W - 1; j >= 0; j--) begin
                shift_bit(cfg_sel[k][j]);
            end
        end
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_en = 1'b1; cfg_din = 1'b1; xin = N_IN'($urandom);
        tick();
        reset = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0;
        checks++; if (ready0 !== 1'b0 || ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b/%b expected 0", ready0, ready1); end
        checks++; if (err0 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b expected 0", err0, err1); end
        checks++; if (dout0 !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b expected 0", dout0); end
        checks++; if (out1 !== 24'h000000) begin errors++; $display("FAIL reset_out_reg: got %h expected 000000", out1); end
        xin = 19'h00001; #1;
        checks++; if (out0 !== 24'hFFFFFF) begin errors++; $display("FAIL reset_route_one: got %h expected ffffff", out0); end
        xin = 19'h00000; #1;
        checks++; if (out0 !== 24'h000000) begin errors++; $display("FAIL reset_route_zero: got %h expected 000000", out0); end
        for (int i = 0; i < 8; i++) begin
            xin = N_IN'($urandom); #1;
            checks++; if (out0 !== route(xin)) begin errors++; $display("FAIL reset_route_rand: got %h expected %h", out0, route(xin)); end
        end
    endtask

    task automatic test_load_commit();
        for (int k = 0; k < N_OUT; k++) cfg_sel[k] = k % N_IN;
        load_cfg();
        checks++; if (ready0 !== 1'b1 || ready1 !== 1'b1) begin errors++; $display("FAIL load_ready: got %b/%b expected 1", ready0, ready1); end
        do_commit();
        checks++; if (ready0 !== 1'b0 || ready1 !== 1'b0) begin errors++; $display("FAIL commit_ready: got %b/%b expected 0", ready0, ready1); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL commit_err: got %b expected 0", err0); end
        xin = 19'h00004; #1;
        checks++; if (out0 !== 24'h200004) begin errors++; $display("FAIL commit_route_bit2: got %h expected 200004", out0); end
        for (int i = 0; i < 8; i++) begin
            xin = N_IN'($urandom);
            tick();
            checks++; if (out0 !== route(xin)) begin errors++; $display("FAIL commit_route_rand: got %h expected %h", out0, route(xin)); end
            checks++; if (out1 !== m_out1) begin errors++; $display("FAIL commit_route_reg: got %h expected %h", out1, m_out1); end
        end
    endtask

    task automatic test_early_commit();
        do_reset();
        for (int k = 0; k < N_OUT; k++) cfg_sel[k] = $urandom_range(0, N_IN - 1);
        load_cfg();
        do_commit();
        for (int i = 0; i < CFG_W - 1; i++) shift_bit(1'($urandom));
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL early_ready: got %b expected 0", ready0); end
        do_commit();
        checks++; if (err0 !== 1'b1 || err1 !== 1'b1) begin errors++; $display("FAIL early_err: got %b/%b expected 1", err0, err1); end
        for (int i = 0; i < 4; i++) begin
            xin = N_IN'($urandom); #1;
            checks++; if (out0 !== route(xin)) begin errors++; $display("FAIL early_route_kept: got %h expected %h", out0, route(xin)); end
        end
        shift_bit(1'($urandom));
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL early_ready_full: got %b expected 1", ready0); end
        do_commit();
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL early_err_sticky: got %b expected 1", err0); end
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL early_commit_ok: got %b expected 0", ready0); end
        for (int i = 0; i < 6; i++) begin
            xin = N_IN'($urandom); #1;
            checks++; if (out0 !== route(xin)) begin errors++; $display("FAIL early_route_new: got %h expected %h", out0, route(xin)); end
        end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < N_OUT; k++) cfg_sel[k] = $urandom_range(0, 31);
        cfg_sel[0] = 31;
        load_cfg();
        do_commit();
        for (int i = 0; i < 16; i++) begin
            xin = (i == 0) ? {N_IN{1'b1}} : N_IN'($urandom); #1;
            checks++; if (out0[0] !== 1'b0) begin errors++; $display("FAIL oor_out0: got %b expected 0", out0[0]); end
            checks++; if (out0 !== route(xin)) begin errors++; $display("FAIL oor_route: got %h expected %h", out0, route(xin)); end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < N_OUT; k++) cfg_sel[k] = $urandom_range(0, N_IN - 1);
        load_cfg();
        cfg_en = 1'b1; cfg_din = 1'($urandom); cfg_commit = 1'b1;
        tick();
        cfg_en = 1'b0; cfg_commit = 1'b0;
        checks++; if (err0 !== 1'b1 || err1 !== 1'b1) begin errors++; $display("FAIL simul_err: got %b/%b expected 1", err0, err1); end
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL simul_ready_sat: got %b expected 1", ready0); end
        xin = 19'h00001; #1;
        checks++; if (out0 !== 24'hFFFFFF) begin errors++; $display("FAIL simul_route_kept: got %h expected ffffff", out0); end
        do_commit();
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL simul_commit_ok: got %b expected 0", ready0); end
        for (int i = 0; i < 4; i++) begin
            xin = N_IN'($urandom); #1;
            checks++; if (out0 !== route(xin)) begin errors++; $display("FAIL simul_route_new: got %h expected %h", out0, route(xin)); end
        end
        for (int i = 0; i < 60; i++) shift_bit(1'($urandom));
        reset = 1'b1; cfg_en = 1'b1; cfg_din = 1'b1; cfg_commit = 1'b1;
        tick();
        reset = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
        checks++; if (ready0 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL midreset_state: got ready %b err %b expected 0 0", ready0, err0); end
        checks++; if (dout0 !== 1'b0 || out1 !== 24'h0) begin errors++; $display("FAIL midreset_out: got dout %b out %h expected 0 000000", dout0, out1); end
        for (int i = 0; i < CFG_W; i++) begin
            shift_bit(1'b0);
            checks++; if (dout0 !== 1'b0 || dout1 !== 1'b0) begin errors++; $display("FAIL midreset_shadow_zero shift %0d: got %b/%b expected 0", i, dout0, dout1); end
        end
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL midreset_recount: got %b expected 1", ready0); end
        do_commit();
        xin = N_IN'($urandom); #1;
        checks++; if (out0 !== {N_OUT{xin[0]}}) begin errors++; $display("FAIL midreset_route: got %h expected %h", out0, {N_OUT{xin[0]}}); end
    endtask

    task automatic test_reg_out();
        logic [N_OUT-1:0] old_exp;
        logic [N_OUT-1:0] prev_out1;
        bit               stream[240];
        for (int k = 0; k < N_OUT; k++) cfg_sel[k] = $urandom_range(0, N_IN - 1);
        cfg_sel[0] = (m_active[0] + 1) % N_IN;
        load_cfg();
        xin = N_IN'($urandom);
        tick();
        old_exp = route(xin);
        do_commit();
        checks++; if (out1 !== old_exp) begin errors++; $display("FAIL reg_commit_edge0: got %h expected %h", out1, old_exp); end
        checks++; if (out0 !== route(xin)) begin errors++; $display("FAIL comb_commit_edge0: got %h expected %h", out0, route(xin)); end
        tick();
        checks++; if (out1 !== route(xin)) begin errors++; $display("FAIL reg_commit_edge1: got %h expected %h", out1, route(xin)); end
        for (int i = 0; i < 8; i++) begin
            prev_out1 = out1;
            xin = N_IN'($urandom); #1;
            checks++; if (out1 !== prev_out1) begin errors++; $display("FAIL reg_hold: got %h expected %h", out1, prev_out1); end
            tick();
            checks++; if (out1 !== route(xin)) begin errors++; $display("FAIL reg_latency: got %h expected %h", out1, route(xin)); end
        end
        for (int i = 0; i < 240; i++) stream[i] = 1'($urandom);
        for (int i = 0; i < 240; i++) begin
            shift_bit(stream[i]);
            if (i >= CFG_W - 1) begin
                checks++; if (dout1 !== stream[i-(CFG_W-1)] || dout0 !== m_dout()) begin
                    errors++; $display("FAIL dout_delay shift %0d: got %b/%b expected %b", i, dout1, dout0, stream[i-(CFG_W-1)]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0; xin = '0;
        m_count = 0; m_err = 1'b0; m_out1 = '0;
        for (int k = 0; k < N_OUT; k++) m_active[k] = 0;
        test_reset();
        test_load_commit();
        test_early_commit();
        test_out_of_range();
        test_simultaneous();
        test_reg_out();
        checks++; if (err0 !== m_err) begin errors++; $display("FAIL final_err: got %b expected %b", err0, m_err); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_xbar.md
CFG_XBAR -- requirements
Module: cfg_xbar

Interface
REQ-001 SHALL have parameter N_IN, default 19, meaning number of crossbar inputs (2..64).
REQ-002 SHALL have parameter N_OUT, default 24, meaning number of crossbar outputs (1..128).
REQ-003 SHALL have parameter REG_OUT, default 0, meaning 1 = registered outputs, 0 = combinational outputs.
REQ-004 SHALL have derived constants SEL_W = ceil(log2(N_IN)) (default 5) and CFG_W = N_OUT*SEL_W (default 120).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port io_xbar_in, input, N_IN, the data inputs.
REQ-008 SHALL have port io_xbar_out, output, N_OUT, the data outputs.
REQ-009 SHALL have port io_cfg_en, input, 1, shifts one config bit when high.
REQ-010 SHALL have port io_cfg_din, input, 1, the serial config bit.
REQ-011 SHALL have port io_cfg_dout, output, 1, equal to shadow[CFG_W-1], for daisy-chaining tiles.
REQ-012 SHALL have port io_cfg_commit, input, 1, a one-cycle request to copy shadow config to active config.
REQ-013 SHALL have port io_cfg_ready, output, 1, high when exactly CFG_W bits have been shifted since the last commit or reset.
REQ-014 SHALL have port io_cfg_err, output, 1, a sticky flag for a rejected commit.

Function
REQ-015 SHALL hold a CFG_W-bit shadow register; when io_cfg_en=1, shadow <= {shadow[CFG_W-2:0], io_cfg_din}.
REQ-016 SHALL place the select for output k at active[k*SEL_W+SEL_W-1 : k*SEL_W].
REQ-017 SHALL keep a bit counter (0..CFG_W) that increments on each shift and saturates at CFG_W; further shifts still move data.
REQ-018 SHALL accept a commit when io_cfg_commit=1, io_cfg_en=0 and count==CFG_W: active <= shadow and count <= 0 in the next cycle.
REQ-019 SHALL otherwise reject the commit, covering count<CFG_W or io_cfg_en=1 in the same cycle: active unchanged, io_cfg_err <= 1, shift proceeds normally.
REQ-020 SHALL clear io_cfg_err only on reset.
REQ-021 SHALL drive io_xbar_out[k] = io_xbar_in[sel_k] when sel_k < N_IN, else 0.
REQ-022 SHALL, with REG_OUT=0, pass io_xbar_out combinationally from io_xbar_in and active config (zero latency); a new config is visible the cycle after an accepted commit.
REQ-023 SHALL, with REG_OUT=1, register io_xbar_out: 1-cycle latency from io_xbar_in, 2 cycles from commit request to new routing at the output.
REQ-024 SHALL leave shadow and io_cfg_dout unaffected by a commit; shadow is retained for rescan.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, set shadow=0, active=0 (all outputs select input 0), count=0, io_cfg_err=0 and, when REG_OUT=1, io_xbar_out=0.
REQ-026 SHALL give reset priority over io_cfg_en and io_cfg_commit in the same cycle; a partial shift is discarded.
REQ-027 SHALL, after reset release with REG_OUT=0, give io_xbar_out[k] = io_xbar_in[0] for all k.

Structure
REQ-028 SHALL place the clog2 function and the default N_IN/N_OUT constants in a shared package xbar_pkg.
REQ-029 SHALL implement each output as one instance of sub-module xbar_mux: N_IN:1 mux with out-of-range zeroing, no state, N_OUT instances.
REQ-030 SHALL keep counter, shadow, active and err logic in cfg_xbar; no other sub-modules.

Verification
REQ-031 SHALL cover reset routing: after reset, io_xbar_in=19'h00001 -> io_xbar_out=24'hFFFFFF; io_xbar_in=0 -> 0.
REQ-032 SHALL cover load and commit: shift 120 bits encoding sel_k = k mod 19, commit -> io_cfg_ready=1 before the commit, then 0; io_xbar_in=19'h00004 -> bits 2 and 21 of io_xbar_out high.
REQ-033 SHALL cover early commit: commit after 119 shifts -> io_cfg_err=1, routing unchanged; a further shift plus commit is accepted and err stays 1.
REQ-034 SHALL cover out-of-range select: sel_0 = 31 -> io_xbar_out[0]=0 for all io_xbar_in.
REQ-035 SHALL cover simultaneous events: io_cfg_en=1 with commit at count==120 -> commit rejected, err=1; reset asserted at shift 60 -> count=0 and shadow=0 next cycle.
REQ-036 SHALL cover REG_OUT=1: an input change appears at io_xbar_out after 1 cycle; routing changes 2 cycles after the commit request; io_cfg_dout reproduces io_cfg_din delayed by 120 shifts.
